// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and constants for the SPI flash arbiter
// Contents:
//   arb_state_t  grant FSM state (IDLE, GNT0, GNT1, GAP)
//   OWN_JTAG/OWN_SOC  owner indices used for the round-robin "last" bit
//   CSN_IDLE/SCK_IDLE/MOSI_IDLE  pad levels when nobody owns the flash
//   MISO_IDLE    level returned to a requester that holds no grant
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        GAP  = 2'd3
    } arb_state_t;

    localparam logic OWN_JTAG  = 1'b0;
    localparam logic OWN_SOC   = 1'b1;

    localparam logic CSN_IDLE  = 1'b1;
    localparam logic SCK_IDLE  = 1'b0;
    localparam logic MOSI_IDLE = 1'b0;
    localparam logic MISO_IDLE = 1'b1;

endpackage

// File: rtl/spi_arb_sync.sv
// rtl/spi_arb_sync.sv - single-bit multi-stage synchronizer with async reset
// Ports:
//   clk  destination clock
//   rst  asynchronous active-high reset, loads RESET_VAL into every stage
//   d    asynchronous input
//   q    synchronized output, STAGES clk edges behind d
// Parameters:
//   STAGES     number of flip-flops (2 or more)
//   RESET_VAL  value held by every stage during reset
module spi_arb_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= {STAGES{RESET_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - two-master arbiter for the configuration SPI flash
// Shares one flash between the JTAG bridge (requester 0, DRCK domain) and the
// SoC SPI master (requester 1, clk domain). Round-robin tie-break, and a
// GAP_CYCLES chip-select-high gap between any two ownerships.
// Optional build macro: SPI_ARB_TIMEOUT_EN (idle-grant watchdog, sets revoked).
// Ports:
//   clk, rst                     system clock, async active-high reset
//   req0, csn0, sck0, mosi0      bridge request and SPI lines (async to clk)
//   gnt0, miso0                  bridge grant (registered) and MISO return
//   req1, csn1, sck1, mosi1      SoC request and SPI lines (clk domain)
//   gnt1, miso1                  SoC grant (registered) and MISO return
//   flash_csn/sck/mosi, flash_miso  flash pads
//   busy                         state is not IDLE
//   revoked                      sticky watchdog flag (0 without the macro)
module spi_flash_arbiter
    import spi_arb_pkg::*;
#(
    parameter int GAP_CYCLES     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic csn0,
    input  logic sck0,
    input  logic mosi0,
    output logic gnt0,
    output logic miso0,
    input  logic req1,
    input  logic csn1,
    input  logic sck1,
    input  logic mosi1,
    output logic gnt1,
    output logic miso1,
    output logic flash_csn,
    output logic flash_sck,
    output logic flash_mosi,
    input  logic flash_miso,
    output logic busy,
    output logic revoked
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    arb_state_t       state;
    logic             last;
    logic [GAP_W-1:0] gap_cnt;
    logic             r0s;
    logic             c0s;
    logic             want0;
    logic             want1;
    logic             gap_done;

    spi_arb_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_req0 (
        .clk (clk),
        .rst (rst),
        .d   (req0),
        .q   (r0s)
    );

    // csn0 resets to the idle level so a fresh grant never sees a phantom frame
    spi_arb_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (CSN_IDLE)
    ) u_sync_csn0 (
        .clk (clk),
        .rst (rst),
        .d   (csn0),
        .q   (c0s)
    );

    // GAP lasts exactly GAP_CYCLES cycles: count 0..GAP_CYCLES-1, then IDLE
    assign gap_done = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             revoked_q;
    logic             blk0;
    logic             blk1;
    logic             own_csn;
    logic             tmo_hit;

    // Chip select of whoever currently owns the flash (bridge side synchronized)
    assign own_csn = (state == GNT0) ? c0s : csn1;
    assign tmo_hit = own_csn && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // A revoked requester is blocked until its request has been seen low
    assign want0   = r0s  & ~blk0;
    assign want1   = req1 & ~blk1;
    assign revoked = revoked_q;
`else
    logic unused_cfg;

    assign want0      = r0s;
    assign want1      = req1;
    assign revoked    = 1'b0;
    assign unused_cfg = c0s & (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            last      <= OWN_SOC;
            gap_cnt   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_cnt   <= '0;
            revoked_q <= 1'b0;
            blk0      <= 1'b0;
            blk1      <= 1'b0;
`endif
        end else begin
`ifdef SPI_ARB_TIMEOUT_EN
            if (!r0s) begin
                blk0 <= 1'b0;
            end
            if (!req1) begin
                blk1 <= 1'b0;
            end
`endif
            unique case (state)
                IDLE: begin
`ifdef SPI_ARB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    // On a tie the requester that did not own last wins
                    if (want0 && (!want1 || last == OWN_SOC)) begin
                        state <= GNT0;
                        gnt0  <= 1'b1;
                        last  <= OWN_JTAG;
                    end else if (want1) begin
                        state <= GNT1;
                        gnt1  <= 1'b1;
                        last  <= OWN_SOC;
                    end
                end

                GNT0: begin
                    if (!r0s) begin
                        state   <= GAP;
                        gnt0    <= 1'b0;
                        gap_cnt <= '0;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state     <= GAP;
                        gnt0      <= 1'b0;
                        gap_cnt   <= '0;
                        revoked_q <= 1'b1;
                        blk0      <= 1'b1;
                    end else if (own_csn) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end else begin
                        tmo_cnt <= '0;
                    end
`endif
                end

                GNT1: begin
                    if (!req1) begin
                        state   <= GAP;
                        gnt1    <= 1'b0;
                        gap_cnt <= '0;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state     <= GAP;
                        gnt1      <= 1'b0;
                        gap_cnt   <= '0;
                        revoked_q <= 1'b1;
                        blk1      <= 1'b1;
                    end else if (own_csn) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end else begin
                        tmo_cnt <= '0;
                    end
`endif
                end

                GAP: begin
                    // Requests arriving here simply stay high and win in IDLE
                    if (gap_done) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

    // Pad select follows the registered state only, so a change of owner is
    // always separated by GAP, where csn is forced high. rst forces the pads
    // directly so a transfer is cut without waiting for any clock edge.
    always_comb begin
        flash_csn  = CSN_IDLE;
        flash_sck  = SCK_IDLE;
        flash_mosi = MOSI_IDLE;
        if (!rst) begin
            unique case (state)
                GNT0: begin
                    flash_csn  = csn0;
                    flash_sck  = sck0;
                    flash_mosi = mosi0;
                end
                GNT1: begin
                    flash_csn  = csn1;
                    flash_sck  = sck1;
                    flash_mosi = mosi1;
                end
                default: begin
                    flash_csn  = CSN_IDLE;
                    flash_sck  = SCK_IDLE;
                    flash_mosi = MOSI_IDLE;
                end
            endcase
        end
    end

    assign miso0 = gnt0 ? flash_miso : MISO_IDLE;
    assign miso1 = gnt1 ? flash_miso : MISO_IDLE;

endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
Shares the single configuration SPI flash (pins CSB, MOSI, CCLK, MISO) between two requesters.
- Requester 0: the JTAG-to-SPI bridge, running in the DRCK domain.
- Requester 1: the SoC SPI master, running in the clk domain.

The arbiter is a grant FSM in the clk domain with a round-robin tie-break and a mandatory chip-select idle gap between owners. It sits between both masters and the flash pads.

Parameters:
- GAP_CYCLES, 4: clk cycles that flash_csn is held high between two ownerships (minimum 1).
- SYNC_STAGES, 2: flip-flop stages on the asynchronous req0 and csn0 inputs (minimum 2).
- TIMEOUT_CYCLES, 1048576: idle-grant watchdog limit. Used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req0  in  1  bridge request (DRCK domain, level, asynchronous to clk)
- csn0, sck0, mosi0  in  1 each  bridge SPI signals
- gnt0  out  1  bridge grant (clk domain, registered; the bridge synchronizes it)
- miso0  out  1  flash MISO to the bridge
- req1  in  1  SoC request (clk domain, level)
- csn1, sck1, mosi1  in  1 each  SoC SPI signals
- gnt1  out  1  SoC grant (registered)
- miso1  out  1  flash MISO to the SoC
- flash_csn, flash_sck, flash_mosi  out  1 each  to pads
- flash_miso  in  1  from pad
- busy  out  1  high when state is not IDLE
- revoked  out  1  sticky watchdog flag (constant 0 without the macro)

Behaviour:
- Reset values: state IDLE; gnt0 = 0, gnt1 = 0, busy = 0, revoked = 0; last = 1, so requester 0 wins the first tie.
  - With rst high, pads are forced immediately and asynchronously: flash_csn = 1, flash_sck = 0, flash_mosi = 0.
  - Reset mid-transfer aborts the transfer; the bridge sees the chip select rise.
- Synchronization: req0 and csn0 each pass through a SYNC_STAGES synchronizer, giving r0s and c0s. req1 is used directly.
- States: IDLE, GNT0, GNT1, GAP.
- IDLE:
  - Only r0s → GNT0.
  - Only req1 → GNT1.
  - Both → grant the requester other than `last`.
  - On entry to GNTx: gntx = 1 and last = x.
- GNTx: remain while the request is high. When the request drops → GAP, with gntx = 0 in the same edge.
- GAP:
  - A GAP_CYCLES counter runs; at terminal count → IDLE.
  - Requests that arrive during GAP are held pending and are arbitrated in IDLE.
- Pad mux:
  - Combinational from the registered state only.
  - GNT0 drives csn0/sck0/mosi0; GNT1 drives csn1/sck1/mosi1.
  - IDLE and GAP drive csn = 1, sck = 0, mosi = 0.
  - The select changes only on the edge that forces csn high, so the flash never sees a partial frame from a new owner.
- MISO fan-out: misox = flash_miso when gntx = 1, else 1.
- Latency:
  - req1 rise to gnt1 = 1 clk from IDLE.
  - req0 rise to gnt0 = SYNC_STAGES + 1 clk.
  - Request drop to grant drop = 1 clk (plus sync stages for req0).
  - Back-to-back ownership: grant of the next requester occurs GAP_CYCLES + 1 clk after the previous grant drops.
- A requester that drops its request while its csn is low is cut off: flash_csn is forced high at GAP entry. This is legal; the requester's frame is lost.
- Counter width is $clog2(GAP_CYCLES+1). The counter is cleared on GAP entry and does not wrap.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- With the macro:
  - In GNTx, a counter of width $clog2(TIMEOUT_CYCLES+1) increments each clk while the owner's csn (c0s or csn1) is high.
  - The counter clears whenever that csn is low.
  - At TIMEOUT_CYCLES the arbiter forces → GAP, drops gntx, and sets revoked = 1. revoked clears only on rst.
  - The revoked requester must drop and re-raise its request to be granted again; a request that stays high is ignored until it has been seen low.
- Without the macro: no counter is built, revoked is tied to 0, and ownership lasts until the request is released.

Decomposition:
- Package spi_arb_pkg holds:
  - the state enum (IDLE, GNT0, GNT1, GAP);
  - the owner index constants (OWN_JTAG = 0, OWN_SOC = 1);
  - the pad idle values (CSN_IDLE = 1, SCK_IDLE = 0).
- One sub-module, spi_arb_sync: a parameterised SYNC_STAGES single-bit synchronizer with asynchronous reset, instantiated for req0 and csn0.

Test Plan:
- req1 = 1 alone from reset → gnt1 = 1 after 1 clk; flash pads follow the csn1/sck1/mosi1 pattern 0x9F bit-exact; miso1 mirrors flash_miso and miso0 = 1.
- req0 and req1 rise on the same clk after reset → gnt0 first. After req0 drops: flash_csn = 1 for exactly 4 clk (GAP_CYCLES = 4), then gnt1 = 1 on the next clk.
- Continuous req0 and req1 toggling over 10 ownerships → strict alternation 0,1,0,1…; at no point are gnt0 and gnt1 both 1; flash_csn is high for at least 4 clk at every handover.
- rst asserted while GNT1 and csn1 = 0 mid-byte → flash_csn = 1 with no clock edge; after release the state is IDLE and no grant is issued until a request is seen.
- req1 dropped while csn1 = 0 → flash_csn rises on the same edge that gnt1 falls; busy stays 1 through GAP and falls after 4 clk.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16: GNT0 with csn0 held high for 16 clk → gnt0 = 0 and revoked = 1; req0 still high → no regrant; drop and re-raise req0 → regrant after SYNC_STAGES + 1 clk.
